// File: rtl/state_sequencer.sv
// -----------------------------------------------------------------------------
// state_sequencer
//
// Purpose:
//   Registers the 5-bit next-state code from the control-unit encoder and
//   decodes the registered code into one-hot control strobes. It also owns
//   the memory request/acknowledge handshake, holding the current state while
//   memory is busy.
//
// Optional feature:
//   MEM_TIMEOUT_EN - when defined, a memory wait longer than TIMEOUT held
//   cycles forces the sequencer back to CLR and sets timeout_err. When
//   undefined, waits are unbounded and timeout_err is tied low.
//
// Ports:
//   clk          in   system clock, rising edge
//   clr_n        in   asynchronous active-low reset
//   next_state   in   next-state code from the encoder (CODE_W)
//   run          in   leave CLR when high
//   halt         in   freeze in the current non-memory state
//   mem_ack      in   memory completes the current request
//   st_clr       out  one-hot CLR strobe
//   st_fetch1    out  one-hot FETCH1 strobe
//   st_fetch2    out  one-hot FETCH2 strobe
//   st_ld1       out  one-hot LD1 strobe
//   st_st1       out  one-hot ST1 strobe
//   exec_valid   out  current state is an execute routine
//   exec_op      out  execute routine index (cur_state[3:0])
//   mem_req      out  memory request (FETCH1, LD1, ST1)
//   mem_wr       out  write qualifier (ST1)
//   cur_state    out  registered state code (CODE_W)
//   instr_count  out  retired-instruction count (CNT_W)
//   illegal_err  out  sticky illegal-code flag
//   timeout_err  out  sticky memory-timeout flag
//
// Handshake: mem_req is a Moore output asserted for the whole time the state
// is a memory state. The request completes on the first rising edge where
// mem_ack=1; mem_ack is ignored in every other state, and halt is ignored
// while a request is outstanding.
// -----------------------------------------------------------------------------
module state_sequencer #(
    parameter int CODE_W  = 5,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [CODE_W-1:0] next_state,
    input  logic              run,
    input  logic              halt,
    input  logic              mem_ack,
    output logic              st_clr,
    output logic              st_fetch1,
    output logic              st_fetch2,
    output logic              st_ld1,
    output logic              st_st1,
    output logic              exec_valid,
    output logic [3:0]        exec_op,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [CODE_W-1:0] cur_state,
    output logic [CNT_W-1:0]  instr_count,
    output logic              illegal_err,
    output logic              timeout_err
);

    localparam logic [4:0] S_CLR    = 5'b10000;
    localparam logic [4:0] S_FETCH1 = 5'b10001;
    localparam logic [4:0] S_FETCH2 = 5'b10100;
    localparam logic [4:0] S_LD1    = 5'b10010;
    localparam logic [4:0] S_ST1    = 5'b10011;

    logic [CODE_W-1:0] r_state;
    logic [CNT_W-1:0]  r_count;
    logic              r_illegal;

    logic              w_is_mem;
    logic              w_mem_wait;
    logic              w_hold;
    logic              w_next_illegal;
    logic              w_timeout;
    logic [CODE_W-1:0] w_next;
    logic              w_set_illegal;

    // Codes 10000..10100 are either named states or unused gaps; only the
    // gaps 10101..11111 are rejected. EXEC codes (MSB=0) are always legal.
    assign w_next_illegal = next_state[4] && (next_state[3:0] > 4'b0100);

    assign w_is_mem   = (r_state == S_FETCH1) || (r_state == S_LD1) ||
                        (r_state == S_ST1);
    assign w_mem_wait = w_is_mem && !mem_ack;

    // Priority: memory wait, CLR without run, halt.
    assign w_hold = w_mem_wait ||
                    ((r_state == S_CLR) && !run) ||
                    halt && !w_is_mem;

`ifdef MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0] r_wait;
    logic              r_timeout;

    // The counter only runs while a request is being held, so it is already
    // zero on entry to the next memory state.
    assign w_timeout = w_mem_wait && (r_wait == WAIT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_wait    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_mem_wait && !w_timeout) begin
                r_wait <= r_wait + 1'b1;
            end else begin
                r_wait <= '0;
            end
            if (w_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        w_next        = r_state;
        w_set_illegal = 1'b0;
        if (w_timeout) begin
            w_next = S_CLR;
        end else if (w_hold) begin
            w_next = r_state;
        end else if (w_next_illegal) begin
            w_next        = S_CLR;
            w_set_illegal = 1'b1;
        end else begin
            w_next = next_state;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state   <= S_CLR;
            r_count   <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            // An instruction retires when the sequencer moves out of FETCH2.
            if ((r_state == S_FETCH2) && (w_next != S_FETCH2)) begin
                r_count <= r_count + 1'b1;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Moore decode of the registered state only.
    assign st_clr      = (r_state == S_CLR);
    assign st_fetch1   = (r_state == S_FETCH1);
    assign st_fetch2   = (r_state == S_FETCH2);
    assign st_ld1      = (r_state == S_LD1);
    assign st_st1      = (r_state == S_ST1);
    assign exec_valid  = !r_state[4];
    assign exec_op     = r_state[3:0];
    assign mem_req     = w_is_mem;
    assign mem_wr      = (r_state == S_ST1);
    assign cur_state   = r_state;
    assign instr_count = r_count;
    assign illegal_err = r_illegal;

endmodule

// File: tb/tb_state_sequencer.sv
module tb_state_sequencer;

  logic        clk;
  logic        clr_n;
  logic [4:0]  next_state;
  logic        run;
  logic        halt;
  logic        mem_ack;
  logic        st_clr, st_fetch1, st_fetch2, st_ld1, st_st1;
  logic        exec_valid;
  logic [3:0]  exec_op;
  logic        mem_req, mem_wr;
  logic [4:0]  cur_state;
  logic [15:0] instr_count;
  logic        illegal_err, timeout_err;

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_q[$];

  state_sequencer dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .next_state  (next_state),
    .run         (run),
    .halt        (halt),
    .mem_ack     (mem_ack),
    .st_clr      (st_clr),
    .st_fetch1   (st_fetch1),
    .st_fetch2   (st_fetch2),
    .st_ld1      (st_ld1),
    .st_st1      (st_st1),
    .exec_valid  (exec_valid),
    .exec_op     (exec_op),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .cur_state   (cur_state),
    .instr_count (instr_count),
    .illegal_err (illegal_err),
    .timeout_err (timeout_err)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Output vector {st_clr,st_fetch1,st_fetch2,st_ld1,st_st1,exec_valid,exec_op,mem_req,mem_wr}
  // required for each state code from the state table.
  function automatic logic [13:0] exp_dec(input logic [4:0] code);
    case (code)
      5'b10000: exp_dec = {6'b100000, code[3:0], 2'b00};
      5'b10001: exp_dec = {6'b010000, code[3:0], 2'b10};
      5'b10100: exp_dec = {6'b001000, code[3:0], 2'b00};
      5'b10010: exp_dec = {6'b000100, code[3:0], 2'b10};
      5'b10011: exp_dec = {6'b000010, code[3:0], 2'b11};
      default:  exp_dec = {6'b000001, code[3:0], 2'b00};
    endcase
  endfunction

  function automatic logic [13:0] act_dec();
    act_dec = {st_clr, st_fetch1, st_fetch2, st_ld1, st_st1, exec_valid,
               exec_op, mem_req, mem_wr};
  endfunction

  // Drive one cycle of inputs, push the required state, then compare after the edge.
  task automatic drive(input string tag, input logic [4:0] ns, input logic r,
                       input logic h, input logic ack, input logic [4:0] exp_state);
    logic [4:0] e;
    next_state = ns;
    run        = r;
    halt       = h;
    mem_ack    = ack;
    exp_q.push_back(exp_state);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val({tag, ".state"}, 32'(cur_state), 32'(e));
    check_val({tag, ".dec"}, 32'(act_dec()), 32'(exp_dec(e)));
  endtask

  initial begin
    clr_n      = 1'b0;
    next_state = 5'b10001;
    run        = 1'b0;
    halt       = 1'b0;
    mem_ack    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.state", 32'(cur_state), 32'h10);
    check_val("rst.dec", 32'(act_dec()), 32'(exp_dec(5'b10000)));
    check_val("rst.count", 32'(instr_count), 32'h0);
    check_val("rst.ill", 32'(illegal_err), 32'h0);
    check_val("rst.to", 32'(timeout_err), 32'h0);
    clr_n = 1'b1;

    // run=0 holds CLR
    for (int i = 0; i < 3; i++) drive("run0", 5'b10001, 1'b0, 1'b0, 1'b1, 5'b10000);

    // fetch loop with single-cycle FETCH1
    drive("f1", 5'b10001, 1'b1, 1'b0, 1'b0, 5'b10001);
    drive("f2", 5'b10100, 1'b1, 1'b0, 1'b1, 5'b10100);
    drive("ex3", 5'b00011, 1'b1, 1'b0, 1'b0, 5'b00011);
    check_val("cnt1", 32'(instr_count), 32'd1);

    // LD1 with four wait cycles
    drive("ld1", 5'b10010, 1'b1, 1'b0, 1'b0, 5'b10010);
    for (int i = 0; i < 4; i++)
      drive("ldwait", 5'(5'b00101 + i[4:0]), 1'b1, 1'b0, 1'b0, 5'b10010);
    drive("ldack", 5'b00101, 1'b1, 1'b0, 1'b1, 5'b00101);

    // halt in EXEC(5)
    for (int i = 0; i < 2; i++) drive("halt5", 5'b10011, 1'b1, 1'b1, 1'b0, 5'b00101);
    drive("st1", 5'b10011, 1'b1, 1'b0, 1'b0, 5'b10011);
    // halt ignored in a memory state
    drive("sthalt", 5'b10001, 1'b1, 1'b1, 1'b1, 5'b10001);
    drive("f2b", 5'b10100, 1'b1, 1'b0, 1'b1, 5'b10100);
    drive("ex7", 5'b00111, 1'b1, 1'b0, 1'b0, 5'b00111);
    check_val("cnt2", 32'(instr_count), 32'd2);

    // illegal code from EXEC
    drive("ill", 5'b10110, 1'b1, 1'b0, 1'b0, 5'b10000);
    check_val("ill.flag", 32'(illegal_err), 32'd1);
    drive("f1c", 5'b10001, 1'b1, 1'b0, 1'b0, 5'b10001);
    drive("f2c", 5'b10100, 1'b1, 1'b0, 1'b1, 5'b10100);
    drive("ex0", 5'b00000, 1'b1, 1'b0, 1'b0, 5'b00000);
    check_val("ill.sticky", 32'(illegal_err), 32'd1);
    check_val("cnt3", 32'(instr_count), 32'd3);
    // random legal EXEC codes, each lasting one cycle
    for (int i = 0; i < 6; i++) begin
      logic [4:0] c;
      c = 5'($urandom_range(0, 15));
      drive("exrnd", c, 1'b1, 1'b0, $urandom_range(0, 1) == 1, c);
    end
    check_val("ill.sticky2", 32'(illegal_err), 32'd1);

    // long wait in FETCH1
    drive("f1d", 5'b10001, 1'b1, 1'b0, 1'b0, 5'b10001);
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 15; i++) drive("towait", 5'b10100, 1'b1, 1'b0, 1'b0, 5'b10001);
    check_val("to.pre", 32'(timeout_err), 32'd0);
    drive("tofire", 5'b10100, 1'b1, 1'b0, 1'b0, 5'b10000);
    check_val("to.flag", 32'(timeout_err), 32'd1);
    drive("f1e", 5'b10001, 1'b1, 1'b0, 1'b0, 5'b10001);
`else
    for (int i = 0; i < 20; i++) drive("nowait", 5'b10100, 1'b1, 1'b0, 1'b0, 5'b10001);
    check_val("to.tied", 32'(timeout_err), 32'd0);
`endif
    drive("f2e", 5'b10100, 1'b1, 1'b0, 1'b1, 5'b10100);
    check_val("cnt.pre", 32'(instr_count), 32'd3);
    drive("ld1e", 5'b10010, 1'b1, 1'b0, 1'b0, 5'b10010);
    check_val("cnt4", 32'(instr_count), 32'd4);
    drive("ldhold", 5'b00001, 1'b1, 1'b0, 1'b0, 5'b10010);

    // asynchronous reset mid-handshake
    #2;
    clr_n = 1'b0;
    #1;
    check_val("rst2.state", 32'(cur_state), 32'h10);
    check_val("rst2.req", 32'(mem_req), 32'h0);
    check_val("rst2.count", 32'(instr_count), 32'h0);
    check_val("rst2.ill", 32'(illegal_err), 32'h0);
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    drive("post", 5'b10001, 1'b0, 1'b0, 1'b1, 5'b10000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
